// File: rtl/timer_prescaler.sv
// Prescaler for the 8-bit timer: produces the one-cycle clk_ena strobe from
// stop, every-clock, power-of-two divided, or synchronized external edge sources.
module timer_prescaler #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       cks,
    input  logic             presc_clr,
    input  logic             ext_tick,
    output logic             clk_ena,
    output logic [DIV_W-1:0] presc_cnt
);

    localparam logic [2:0] MODE_EXT_RISE = 3'd6;
    localparam logic [2:0] MODE_EXT_FALL = 3'd7;

    logic [2:0] cks_q;
    logic       ext_s1;
    logic       ext_s2;
    logic       ext_h;
    logic       entry;
    logic       count_mode;
    logic       div_mode;
    logic       div_hit;
    logic       ena_next;
    int         mode_i;

    // A clear is treated exactly like a mode change so the phase realigns identically.
    always_comb begin
        mode_i     = int'({29'd0, cks_q});
        entry      = (cks != cks_q) || presc_clr;
        count_mode = (mode_i >= 1) && (mode_i <= DIV_W + 1);
        div_mode   = (mode_i >= 2) && (mode_i <= DIV_W + 1);
        div_hit    = 1'b1;
        for (int i = 0; i < DIV_W; i++) begin
            if (i < mode_i - 1) begin
                div_hit = div_hit & presc_cnt[i];
            end
        end
        ena_next = 1'b0;
        if (cks_q == MODE_EXT_RISE) begin
            ena_next = ext_s2 & ~ext_h;
        end else if (cks_q == MODE_EXT_FALL) begin
            ena_next = ~ext_s2 & ext_h;
        end else if (mode_i == 1) begin
            ena_next = 1'b1;
        end else if (div_mode) begin
            ena_next = div_hit;
        end
    end

    // The synchronizer and edge history run in every mode, so entering an
    // external mode always compares against an up-to-date level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_s1 <= 1'b0;
            ext_s2 <= 1'b0;
            ext_h  <= 1'b0;
        end else begin
            ext_s1 <= ext_tick;
            ext_s2 <= ext_s1;
            ext_h  <= ext_s2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cks_q     <= 3'd0;
            presc_cnt <= '0;
            clk_ena   <= 1'b0;
        end else if (entry) begin
            cks_q     <= cks;
            presc_cnt <= '0;
            clk_ena   <= 1'b0;
        end else begin
            clk_ena   <= ena_next;
            presc_cnt <= count_mode ? presc_cnt + 1'b1 : '0;
        end
    end

endmodule

// File: tb/tb_timer_prescaler.sv
// Randomized bench for timer_prescaler against a cycles-since-entry reference model.
module tb_timer_prescaler;

    localparam int DIV_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       cks;
    logic             presc_clr;
    logic             ext_tick;
    logic             clk_ena;
    logic [DIV_W-1:0] presc_cnt;

    int vectors     = 0;
    int miscompares = 0;

    int m_mode;
    int m_k;
    int m_ena;
    int m_cnt;
    bit x1, x2, x3;
    int ext_hold;
    int strobes;

    timer_prescaler #(.DIV_W(DIV_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cks       (cks),
        .presc_clr (presc_clr),
        .ext_tick  (ext_tick),
        .clk_ena   (clk_ena),
        .presc_cnt (presc_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic modelReset();
        m_mode = 0;
        m_k    = 0;
        m_ena  = 0;
        m_cnt  = 0;
        x1 = 1'b0;
        x2 = 1'b0;
        x3 = 1'b0;
    endtask

    // Model in terms of edges since the last entry edge and the sampled ext history.
    task automatic modelStep(input logic [2:0] c, input logic clr, input logic e);
        bit is_entry;
        is_entry = (int'(c) != m_mode) || clr;
        if (is_entry) begin
            m_mode = int'(c);
            m_k    = 0;
            m_ena  = 0;
        end else begin
            m_k++;
            if (m_mode == 1)
                m_ena = 1;
            else if (m_mode >= 2 && m_mode <= DIV_W + 1)
                m_ena = ((m_k % (1 << (m_mode - 1))) == 0) ? 1 : 0;
            else if (m_mode == 6)
                m_ena = (x2 && !x3) ? 1 : 0;
            else if (m_mode == 7)
                m_ena = (!x2 && x3) ? 1 : 0;
            else
                m_ena = 0;
        end
        m_cnt = (!is_entry && m_mode >= 1 && m_mode <= DIV_W + 1) ? (m_k % (1 << DIV_W)) : 0;
        x3 = x2;
        x2 = x1;
        x1 = e;
    endtask

    task automatic applyStimulus(input logic [2:0] c, input logic clr, input logic e);
        cks       = c;
        presc_clr = clr;
        if (e != ext_tick) ext_hold = 0;
        ext_tick  = e;
        @(posedge clk);
        modelStep(c, clr, e);
        ext_hold++;
        @(negedge clk);
        checkOutput("clk_ena", int'(clk_ena), m_ena);
        checkOutput("presc_cnt", int'(presc_cnt), m_cnt);
        strobes += int'(clk_ena);
    endtask

    // Called just after a negedge; reset lands mid-cycle, outputs must drop at once.
    task automatic doReset();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_clk_ena", int'(clk_ena), 0);
        checkOutput("rst_presc_cnt", int'(presc_cnt), 0);
        modelReset();
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_hold_ena", int'(clk_ena), 0);
        rst = 1'b0;
    endtask

    initial begin
        logic [2:0] c;
        logic       clr;
        logic       e;

        rst       = 1'b1;
        cks       = 3'd0;
        presc_clr = 1'b0;
        ext_tick  = 1'b0;
        ext_hold  = 10;
        strobes   = 0;
        modelReset();

        #2;
        checkOutput("reset_clk_ena", int'(clk_ena), 0);
        checkOutput("reset_presc_cnt", int'(presc_cnt), 0);
        @(negedge clk);
        rst = 1'b0;

        // Divide by 4 from reset: strobes after E4, E8, E12.
        repeat (13) applyStimulus(3'd3, 1'b0, 1'b0);

        // Switch /2 -> /16 mid-run.
        repeat (6) applyStimulus(3'd2, 1'b0, 1'b0);
        repeat (40) applyStimulus(3'd5, 1'b0, 1'b0);

        // Divide by 8, clear at count 5, then count strobes over 64 cycles.
        repeat (6) applyStimulus(3'd4, 1'b0, 1'b0);
        checkOutput("div8_pre_clear_cnt", int'(presc_cnt), 5);
        applyStimulus(3'd4, 1'b1, 1'b0);
        strobes = 0;
        repeat (64) applyStimulus(3'd4, 1'b0, 1'b0);
        checkOutput("div8_strobes", strobes, 8);

        // External rising edges, then falling-edge mode entered while high.
        repeat (5) applyStimulus(3'd6, 1'b0, 1'b0);
        strobes = 0;
        repeat (3) begin
            repeat (5) applyStimulus(3'd6, 1'b0, 1'b1);
            repeat (5) applyStimulus(3'd6, 1'b0, 1'b0);
        end
        checkOutput("ext_rise_strobes", strobes, 3);
        repeat (5) applyStimulus(3'd6, 1'b0, 1'b1);
        strobes = 0;
        repeat (6) applyStimulus(3'd7, 1'b0, 1'b1);
        checkOutput("ext_fall_no_stale", strobes, 0);
        repeat (6) applyStimulus(3'd7, 1'b0, 1'b0);
        checkOutput("ext_fall_strobes", strobes, 1);

        // Every clock for 10 cycles, then stop.
        strobes = 0;
        repeat (10) applyStimulus(3'd1, 1'b0, 1'b0);
        checkOutput("mode1_strobes", strobes, 9);
        repeat (3) applyStimulus(3'd0, 1'b0, 1'b0);

        // Reset while a /4 strobe is high, then restart in /4.
        applyStimulus(3'd3, 1'b0, 1'b0);
        for (int i = 0; i < 8 && clk_ena == 1'b0; i++) applyStimulus(3'd3, 1'b0, 1'b0);
        checkOutput("pre_rst_strobe", int'(clk_ena), 1);
        doReset();
        strobes = 0;
        repeat (5) applyStimulus(3'd3, 1'b0, 1'b0);
        checkOutput("post_rst_strobes", strobes, 1);

        // Randomized mode changes, clears, external levels and resets.
        for (int n = 0; n < 2000; n++) begin
            c   = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : cks;
            clr = ($urandom_range(0, 31) == 0);
            e   = (ext_hold >= 2 && $urandom_range(0, 2) == 0) ? ~ext_tick : ext_tick;
            applyStimulus(c, clr, e);
            if ($urandom_range(0, 299) == 0) doReset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/timer_prescaler.md
Name: timer_prescaler

Overview:
- Upstream stage of the 8-bit timer counter; generates the single-cycle `clk_ena` strobe that advances the counter.
- Contains a free-running binary divider. A clock-select field picks stop, every clock, a power-of-two division, or a synchronized external tick edge.
- Provides a synchronous clear so the timer can realign the prescaler phase when it reloads `start_counter`.

Parameters:
- DIV_W, 4, divider width; supported divisions are 2^1 .. 2^DIV_W (4 gives /2, /4, /8, /16).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cks  in  3  clock select: 0 stop, 1 every clk, 2..5 = /2,/4,/8,/16, 6 ext rising edge, 7 ext falling edge.
- presc_clr  in  1  synchronous divider clear; the timer drives it with its load pulse.
- ext_tick  in  1  asynchronous external count source.
- clk_ena  out  1  registered one-cycle enable strobe to the counter.
- presc_cnt  out  DIV_W  current divider value, for debug/readback.

Behaviour:
- Reset (rst=1, asynchronous): all registers clear immediately.
  - clk_ena=0, presc_cnt=0, internal cks_q=0 (stop mode).
  - Synchronizer FFs and edge history = 0.
- Mode-change detection: a rising clk edge where cks != cks_q is a **mode-entry edge**. At that edge:
  - cks_q <= cks, presc_cnt <= 0, clk_ena <= 0.
  - The external edge history is loaded with the current synchronized value, so a stale level never produces a pulse.
- presc_clr=1 at an edge has exactly the same effect as a mode-entry edge (cks_q <= cks).
  - presc_clr and a cks change together: a single entry edge, no extra effect.
- Divider: outside entry edges, presc_cnt increments by 1 every clk in modes 1..5 and wraps 2^DIV_W-1 -> 0.
  - In modes 0, 6 and 7, presc_cnt holds 0.
- Mode 0 (stop): clk_ena stays 0.
- Mode 1: clk_ena=1 after every edge except the entry edge. With entry edge E0, the first strobe is after E1.
- Modes 2..DIV_W+1, n = cks-1:
  - At each non-entry edge, clk_ena <= (presc_cnt[n-1:0] == all ones).
  - With entry edge E0, strobes occur after edges E(2^n), E(2*2^n), and so on; each is exactly one cycle wide.
- Modes 6/7:
  - ext_tick passes through a 2-FF synchronizer (s1 -> s2). The FFs run in every mode.
  - The edge history register h <= s2 at every edge.
  - clk_ena <= s2 & ~h (mode 6) or ~s2 & h (mode 7).
  - Latency: ext_tick stable before edge A gives a strobe after edge A+2.
  - Pulses spaced closer than 2 clk cycles may merge. The source must hold each level for at least 2 cycles.
- cks values above DIV_W+1 and below 6 (only possible when DIV_W<4) behave as mode 0.
- clk_ena is glitch-free, registered, and never high for 2 consecutive cycles except in mode 1.
- rst asserted mid-operation: the strobe is cancelled within the same cycle (asynchronously).
  - After release the block sits in stop mode. The first edge with cks!=0 is an entry edge.

Test Plan:
- Reset then cks=3 (/4), presc_clr=0; take the first post-reset edge as E0 -> clk_ena high after E4, E8, E12; low elsewhere; presc_cnt counts 0,1,2,3,0,...
- cks=2 running; switch to cks=5 at edge E0 -> no strobe at E0; next strobe after E16, then every 16 cycles; presc_cnt restarts at 0 after E0.
- cks=4 (/8) with presc_cnt=5; pulse presc_clr for one cycle -> presc_cnt=0 after that edge; next strobe 8 edges later (not 2); strobe count over 64 cycles = 8 after the clear.
- cks=6; drive ext_tick low->high 3 times, each level held 5 cycles -> exactly 3 one-cycle strobes, each after the 3rd edge from the ext_tick rise. Switch to cks=7 with ext_tick already high -> no strobe until ext_tick falls.
- cks=1 for 10 cycles -> 9 strobes (none on the entry edge). Then cks=0 -> clk_ena low from the next edge; presc_cnt=0.
- cks=3 running; assert rst asynchronously mid-cycle while clk_ena=1 -> clk_ena and presc_cnt drop to 0 before the next edge. Release rst with cks=3 -> the first edge is an entry edge and the first strobe comes 4 edges later.
